// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the L0 cache read/write paths.
//
// Contents:
//   LineDataWidth / LineTagWidth / LineValidWidth - geometry of one cache line view
//   cache_line_view_t  - {data, tag, per-byte valid} as seen by the read side
//   cache_read_state_e - read-controller FSM states
//   cache_merge_write  - overlays a cache write onto a line view
package riscv_pkg;

    localparam int unsigned LineDataWidth  = 32;
    localparam int unsigned LineTagWidth   = 7;
    localparam int unsigned LineValidWidth = LineDataWidth / 8;

    typedef struct packed {
        logic [LineDataWidth-1:0]  data;
        logic [LineTagWidth-1:0]   tag;
        logic [LineValidWidth-1:0] valid;
    } cache_line_view_t;

    typedef enum logic {
        StRun,
        StHold
    } cache_read_state_e;

    // Byte-enabled data overlay; tag and valid bits are replaced wholesale because the write
    // path already presents the final merged valid mask.
    function automatic cache_line_view_t cache_merge_write(
        input cache_line_view_t          line,
        input logic                      we,
        input logic [LineValidWidth-1:0] bwe,
        input logic [LineDataWidth-1:0]  data,
        input logic [LineTagWidth-1:0]   tag,
        input logic [LineValidWidth-1:0] valid
    );
        cache_line_view_t merged;
        merged = line;
        if (we) begin
            for (int b = 0; b < int'(LineValidWidth); b++) begin
                if (bwe[b]) begin
                    merged.data[8*b +: 8] = data[8*b +: 8];
                end
            end
            merged.tag   = tag;
            merged.valid = valid;
        end
        return merged;
    endfunction

endpackage

// File: rtl/cache_read_controller.sv
// Read side of the L0 data cache. Presents the read index in EX, resolves hit/miss in MA, and
// delivers the cached word with any in-flight cache writes merged in so MA never sees stale data.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_stall, i_flush             pipeline hold / squash of the instruction entering MA
//   i_load_request_ex            EX holds a load
//   i_data_memory_address_ex     EX load address
//   i_byte_read_mask_ex          bytes required by the load
//   o_cache_read_index           cache read-port address (sync read, 1-cycle, read-first)
//   i_cache_read_data/tag/valid  cache read-port line, one cycle after the index
//   i_cache_write_*              snooped cache write port
//   o_request_valid_ma           MA holds a cacheable load
//   o_hit_ma, o_read_data_ma     MA hit and merged line data
//   o_hit_count, o_miss_count    saturating load hit/miss counters
//
// The line view uses the package geometry; XLEN and CacheTagWidth must match it.
module cache_read_controller
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN            = LineDataWidth,
    parameter int unsigned     CacheIndexWidth = 7,
    parameter int unsigned     CacheTagWidth   = LineTagWidth,
    parameter logic [XLEN-1:0] MMIO_ADDR       = 32'h4000_0000,
    parameter int unsigned     CounterWidth    = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_stall,
    input  logic                       i_flush,
    input  logic                       i_load_request_ex,
    input  logic [XLEN-1:0]            i_data_memory_address_ex,
    input  logic [XLEN/8-1:0]          i_byte_read_mask_ex,
    output logic [CacheIndexWidth-1:0] o_cache_read_index,
    input  logic [XLEN-1:0]            i_cache_read_data,
    input  logic [CacheTagWidth-1:0]   i_cache_read_tag,
    input  logic [XLEN/8-1:0]          i_cache_read_valid,
    input  logic                       i_cache_write_enable,
    input  logic [CacheIndexWidth-1:0] i_cache_write_index,
    input  logic [XLEN/8-1:0]          i_cache_byte_write_enable,
    input  logic [XLEN-1:0]            i_cache_write_data,
    input  logic [CacheTagWidth-1:0]   i_cache_write_tag,
    input  logic [XLEN/8-1:0]          i_cache_write_valid,
    output logic                       o_request_valid_ma,
    output logic                       o_hit_ma,
    output logic [XLEN-1:0]            o_read_data_ma,
    output logic [CounterWidth-1:0]    o_hit_count,
    output logic [CounterWidth-1:0]    o_miss_count
);

    // ---------------------------------------------------------------- EX decode / read index
    logic [CacheIndexWidth-1:0] index_ex;
    logic [CacheTagWidth-1:0]   tag_ex;
    logic                       cacheable_ex;

    assign index_ex     = i_data_memory_address_ex[2 +: CacheIndexWidth];
    assign tag_ex       = i_data_memory_address_ex[(2+CacheIndexWidth) +: CacheTagWidth];
    assign cacheable_ex = (i_data_memory_address_ex < MMIO_ADDR);

    // MA stage fields
    logic                       req_ma_q;
    logic [CacheIndexWidth-1:0] idx_ma_q;
    logic [CacheTagWidth-1:0]   tag_ma_q;
    logic [XLEN/8-1:0]          mask_ma_q;

    // Re-present the MA index while stalled so the read port keeps tracking the MA line.
    assign o_cache_read_index = i_stall ? idx_ma_q : index_ex;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            req_ma_q <= 1'b0;
        end else if (!i_stall) begin
            req_ma_q <= i_load_request_ex & cacheable_ex;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_stall) begin
            idx_ma_q  <= index_ex;
            tag_ma_q  <= tag_ex;
            mask_ma_q <= i_byte_read_mask_ex;
        end
    end

    // ---------------------------------------------------------------- write snoop
    // The read port is read-first, so a write to the presented index in the same cycle is not
    // visible in next cycle's read data; capture it here and overlay it.
    logic                     snoop_hit_q;
    logic [XLEN/8-1:0]        snoop_bwe_q;
    logic [XLEN-1:0]          snoop_data_q;
    logic [CacheTagWidth-1:0] snoop_tag_q;
    logic [XLEN/8-1:0]        snoop_valid_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            snoop_hit_q <= 1'b0;
        end else begin
            snoop_hit_q <= i_cache_write_enable & (i_cache_write_index == o_cache_read_index);
        end
    end

    always_ff @(posedge i_clk) begin
        snoop_bwe_q   <= i_cache_byte_write_enable;
        snoop_data_q  <= i_cache_write_data;
        snoop_tag_q   <= i_cache_write_tag;
        snoop_valid_q <= i_cache_write_valid;
    end

    // ---------------------------------------------------------------- line view / hold FSM
    cache_read_state_e state_q, state_d;
    cache_line_view_t  hold_q;
    cache_line_view_t  port_line;
    cache_line_view_t  base_line;
    cache_line_view_t  line_view;
    logic              hold_select;
    logic              hold_capture;

    assign port_line = '{data: i_cache_read_data, tag: i_cache_read_tag,
                         valid: i_cache_read_valid};
    assign base_line = hold_select ? hold_q : port_line;
    assign line_view = cache_merge_write(base_line, snoop_hit_q, snoop_bwe_q, snoop_data_q,
                                         snoop_tag_q, snoop_valid_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (i_stall && req_ma_q) state_d = StHold;
            StHold:  if (!i_stall) state_d = StRun;
            default: state_d = StRun;
        endcase
        if (i_flush) begin
            state_d = StRun;
        end
    end

    // The exit cycle of HOLD still presents the held view: the read port was fed idx_ma only
    // while stalled, so its data in that cycle is already correct too, but the hold copy is
    // the authoritative one.
    always_comb begin
        hold_select  = (state_q == StHold);
        hold_capture = (state_q == StHold) || (i_stall && req_ma_q);
    end

    always_ff @(posedge i_clk) begin
        if (hold_capture) begin
            hold_q <= line_view;
        end
    end

    // ---------------------------------------------------------------- outputs
    logic hit_ma;

    assign hit_ma = req_ma_q && (line_view.tag == tag_ma_q)
                    && ((line_view.valid & mask_ma_q) == mask_ma_q);

    assign o_hit_ma           = hit_ma;
    assign o_read_data_ma     = line_view.data;
    assign o_request_valid_ma = req_ma_q;

    // ---------------------------------------------------------------- performance counters
    logic [CounterWidth-1:0] hit_count_q;
    logic [CounterWidth-1:0] miss_count_q;
    logic                    count_en;

    assign count_en = req_ma_q & ~i_stall & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (count_en) begin
            if (hit_ma) begin
                if (hit_count_q != '1) hit_count_q <= hit_count_q + 1'b1;
            end else begin
                if (miss_count_q != '1) miss_count_q <= miss_count_q + 1'b1;
            end
        end
    end

    assign o_hit_count  = hit_count_q;
    assign o_miss_count = miss_count_q;

endmodule

// File: doc/cache_read_controller.md
Name: cache_read_controller

Overview:
- Read-side companion to the L0 cache write path: drives the cache read index in EX, then resolves hit/miss in MA.
- Compares the stored tag and per-byte valid bits against the load's byte mask, and delivers the cached word.
- Merges same-cycle and stall-window cache writes so MA never sees stale contents.
- Keeps a held copy of the line across stalls, and counts load hits and misses for performance monitoring.

Parameters:
XLEN, 32, data word width
CacheIndexWidth, 7, cache index bits, taken from address bits [2 +: CacheIndexWidth]
CacheTagWidth, 7, tag bits, taken from address bits [(2+CacheIndexWidth) +: CacheTagWidth]
MMIO_ADDR, 32'h4000_0000, addresses at or above this value are uncacheable
CounterWidth, 32, width of the hit and miss counters

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_stall  in  1  pipeline stall; EX/MA hold
i_flush  in  1  squash the instruction entering MA
i_load_request_ex  in  1  EX holds a load
i_data_memory_address_ex  in  XLEN  EX load address
i_byte_read_mask_ex  in  XLEN/8  bytes required by the load (LB/LH/LW, aligned)
o_cache_read_index  out  CacheIndexWidth  cache read-port address (synchronous read, 1-cycle latency, read-first)
i_cache_read_data  in  XLEN  line data, one cycle after the index
i_cache_read_tag  in  CacheTagWidth  line tag
i_cache_read_valid  in  XLEN/8  line per-byte valid bits
i_cache_write_enable  in  1  cache write-port enable (snooped)
i_cache_write_index  in  CacheIndexWidth  write index
i_cache_byte_write_enable  in  XLEN/8  write byte enables
i_cache_write_data  in  XLEN  write data
i_cache_write_tag  in  CacheTagWidth  write tag
i_cache_write_valid  in  XLEN/8  final valid bits written (already merged)
o_request_valid_ma  out  1  MA holds a cacheable load
o_hit_ma  out  1  MA load hits: tag match and every masked byte valid
o_read_data_ma  out  XLEN  merged line data, valid when o_hit_ma
o_hit_count  out  CounterWidth  saturating count of load hits
o_miss_count  out  CounterWidth  saturating count of load misses

Behaviour:
- Read index select:
  - o_cache_read_index = i_stall ? idx_ma : address_ex[2 +: CacheIndexWidth].
  - While stalled the MA index is re-presented (combinational).
- MA registers: req_ma, idx_ma, tag_ma, mask_ma.
  - Load when ~i_stall.
  - req_ma <= i_load_request_ex & (address_ex < MMIO_ADDR).
  - On i_rst or i_flush, req_ma <= 0; the other fields are don't-care.
- Write snoop register:
  - Each cycle, capture snoop_hit <= i_cache_write_enable & (i_cache_write_index == index presented this cycle), together with the byte enables, data, tag and valid bits.
  - Cleared on i_rst.
- Merge rule (line view L = {data, tag, valid}), applied when snoop_hit:
  - data bytes with byte_we set take the write data.
  - tag := write tag; valid := write valid.
  - Otherwise L is unchanged.
- State machine:
  - RUN: L = merge(cache read port, snoop).
  - On the first cycle with i_stall & req_ma: capture L into hold regs and go to HOLD.
  - HOLD: L = merge(hold regs, snoop). The hold regs update with L every cycle.
  - HOLD -> RUN when ~i_stall. Data presented in that cycle is still the held/merged view.
  - i_flush or i_rst forces RUN.
- Outputs:
  - o_hit_ma = req_ma & (L.tag == tag_ma) & ((L.valid & mask_ma) == mask_ma).
  - o_read_data_ma = L.data.
  - o_request_valid_ma = req_ma.
- Counters:
  - On a cycle with req_ma & ~i_stall & ~i_flush, increment o_hit_count if o_hit_ma, else o_miss_count.
  - Both saturate at all-ones and reset to 0.
- Reset values: all outputs 0; state RUN.
- Simultaneous events:
  - Flush during HOLD: drop to RUN with req_ma = 0; no count.
  - Write to a different index: no effect.
  - Back-to-back writes during HOLD accumulate in order.
- MMIO loads: never valid in MA and never counted.

Decomposition:
- Shared package riscv_pkg gains typedef cache_line_view_t {data, tag, valid} and the function cache_merge_write(line, we, bwe, data, tag, valid).
- No sub-module; the counters are simple enough to stay inline.

Test Plan:
- Cold miss: reset, LW 0x0000_0100 with the line invalid -> o_hit_ma=0, o_miss_count=1, o_hit_count=0.
- Hit after fill: write index 0x40, tag 0, valid 4'hF, data 0xDEADBEEF, then LW 0x100 -> o_hit_ma=1, data 0xDEADBEEF, o_hit_count=1.
- Same-cycle bypass:
  - Setup: line holds 0x11223344.
  - Stimulus: a store of byte 0xAA (bwe 4'b0001) to index 0x40 in the same cycle as an LB EX read.
  - Expected: MA data 0x112233AA, hit.
- Stall hold:
  - Setup: a load to 0x100 reaches MA.
  - Stimulus: hold i_stall for 5 cycles while a write of 0xCAFEF00D (bwe 4'hF) hits index 0x40 in cycle 3.
  - Expected: after release, data 0xCAFEF00D; exactly one hit counted.
- Partial valid: line valid 4'b0011; LH at offset 0 -> hit; LW -> miss. Tag mismatch (tag 1 vs 0) -> miss.
- MMIO and flush:
  - LW 0x4000_0000 -> o_request_valid_ma=0, counters unchanged.
  - A flush in the same cycle as a load enters MA -> no count.
  - Force o_miss_count to all-ones, then miss -> stays all-ones.
